// File: rtl/fb_scanout_if.sv
// Framebuffer read port: the scan-out side drives the address and the RAM returns
// data one clock later, qualified by fb_rvalid (RAM not busy writing).
interface fb_scanout_if #(
  parameter int AW = 9
);
  logic [AW-1:0] fb_addr;
  logic [23:0]   fb_rdata;
  logic          fb_rvalid;

  modport master (output fb_addr, input fb_rdata, input fb_rvalid);
  modport slave  (input fb_addr, output fb_rdata, output fb_rvalid);
endinterface

// File: rtl/fb_scanout.sv
// Raster timing generator and upscaling framebuffer reader with a 3-clock aligned output pipeline.
// Optional colour-bar test pattern is compiled in when FB_SCANOUT_PATTERN_EN is defined.
module fb_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FB_W       = 32,
  parameter int FB_H       = 16,
  parameter int SCALE_LOG2 = 4,
  parameter int DP         = 512
) (
  input  logic         clk,
  input  logic         rst,
  fb_scanout_if.master fb,
`ifdef FB_SCANOUT_PATTERN_EN
  input  logic         pat_en_i,
`endif
  output logic         hsync_o,
  output logic         vsync_o,
  output logic         de_o,
  output logic [23:0]  rgb_o,
  output logic         frame_start_o
);
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW        = $clog2(H_TOTAL);
  localparam int VW        = $clog2(V_TOTAL);
  localparam int AW        = $clog2(DP);
  localparam bit FB_W_POW2 = (FB_W & (FB_W - 1)) == 0;
  localparam int FB_W_LOG2 = $clog2(FB_W);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [AW-1:0] fb_addr_q, fb_addr_d;
  logic [2:0]    hsPipe_q, vsPipe_q, dePipe_q, fsPipe_q;
  logic [1:0]    inFbPipe_q;
  logic          rvalid_q;
  logic [23:0]   rgb_q, rgb_d;
  logic          hsRaw, vsRaw, deRaw, fsRaw, inFbRaw;
  logic [31:0]   px, py;

  always_comb begin
    hcnt_d = hcnt_q + HW'(1);
    vcnt_d = vcnt_q;
    if (hcnt_q == HW'(H_TOTAL - 1)) begin
      hcnt_d = '0;
      if (vcnt_q == VW'(V_TOTAL - 1)) vcnt_d = '0;
      else                            vcnt_d = vcnt_q + VW'(1);
    end
  end

  // Address math is done at 32 bits and truncated only when it lands in fb_addr.
  always_comb begin
    px      = 32'(hcnt_q >> SCALE_LOG2);
    py      = 32'(vcnt_q >> SCALE_LOG2);
    deRaw   = (32'(hcnt_q) < H_ACTIVE) && (32'(vcnt_q) < V_ACTIVE);
    hsRaw   = !((32'(hcnt_q) >= H_ACTIVE + H_FP) && (32'(hcnt_q) < H_ACTIVE + H_FP + H_SYNC));
    vsRaw   = !((32'(vcnt_q) >= V_ACTIVE + V_FP) && (32'(vcnt_q) < V_ACTIVE + V_FP + V_SYNC));
    fsRaw   = (hcnt_q == '0) && (vcnt_q == '0);
    inFbRaw = (px < FB_W) && (py < FB_H);
    fb_addr_d = fb_addr_q;
    if (deRaw && inFbRaw) begin
      if (FB_W_POW2) fb_addr_d = AW'((py << FB_W_LOG2) + px);
      else           fb_addr_d = AW'((py * FB_W) + px);
    end
  end

`ifdef FB_SCANOUT_PATTERN_EN
  logic [2:0] barRaw, bar1_q, bar2_q;

  function automatic logic [23:0] barColour(input logic [2:0] idx);
    case (idx)
      3'd0:    barColour = 24'hFFFFFF;
      3'd1:    barColour = 24'hFFFF00;
      3'd2:    barColour = 24'h00FFFF;
      3'd3:    barColour = 24'h00FF00;
      3'd4:    barColour = 24'hFF00FF;
      3'd5:    barColour = 24'hFF0000;
      3'd6:    barColour = 24'h0000FF;
      default: barColour = 24'h000000;
    endcase
  endfunction

  always_comb barRaw = 3'((32'(hcnt_q) * 32'd8) / 32'(H_ACTIVE));

  always_ff @(posedge clk) begin
    if (rst) begin
      bar1_q <= '0;
      bar2_q <= '0;
    end else begin
      bar1_q <= barRaw;
      bar2_q <= bar1_q;
    end
  end
`endif

  // Stage 3: the flags two deep line up with RAM data sampled one edge earlier.
  always_comb begin
    rgb_d = rgb_q;
    if (!dePipe_q[1])
      rgb_d = '0;
`ifdef FB_SCANOUT_PATTERN_EN
    else if (pat_en_i)
      rgb_d = barColour(bar2_q);
`endif
    else if (!inFbPipe_q[1])
      rgb_d = '0;
    else if (rvalid_q)
      rgb_d = fb.fb_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      fb_addr_q  <= '0;
      hsPipe_q   <= '1;
      vsPipe_q   <= '1;
      dePipe_q   <= '0;
      fsPipe_q   <= '0;
      inFbPipe_q <= '0;
      rvalid_q   <= 1'b0;
      rgb_q      <= '0;
    end else begin
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      fb_addr_q  <= fb_addr_d;
      hsPipe_q   <= {hsPipe_q[1:0], hsRaw};
      vsPipe_q   <= {vsPipe_q[1:0], vsRaw};
      dePipe_q   <= {dePipe_q[1:0], deRaw};
      fsPipe_q   <= {fsPipe_q[1:0], fsRaw};
      inFbPipe_q <= {inFbPipe_q[0], inFbRaw};
      rvalid_q   <= fb.fb_rvalid;
      rgb_q      <= rgb_d;
    end
  end

  assign fb.fb_addr      = fb_addr_q;
  assign hsync_o         = hsPipe_q[2];
  assign vsync_o         = vsPipe_q[2];
  assign de_o            = dePipe_q[2];
  assign frame_start_o   = fsPipe_q[2];
  assign rgb_o           = rgb_q;
endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout on a reduced 14x7 raster; dutA holds a 4x2 framebuffer,
// dutB a 2x1 framebuffer so that out-of-framebuffer pixels are exercised as well.
module tb_fb_scanout;
  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic rvalid = 1'b1;
  logic patEn  = 1'b0;
  always #5 clk = ~clk;

  fb_scanout_if #(.AW(9)) fbA ();
  fb_scanout_if #(.AW(9)) fbB ();
  logic        hsA, vsA, deA, fsA, hsB, vsB, deB, fsB;
  logic [23:0] rgbA, rgbB;

  logic [23:0] barTab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  typedef struct {
    int         h;
    int         v;
    logic       hs, vs, de, fs;
    logic       inA, inB;
    logic [8:0] addrA, addrB;
    logic [2:0] bar;
    logic       rv, pe;
  } entry_t;

  entry_t      q[$];
  int          hm = 0, vm = 0;
  bit          expOk = 1'b0;
  logic [55:0] expVec = '0;
  int          expH = 0, expV = 0;
  logic [23:0] prevA = '0, prevB = '0;
  int          total = 0, bad = 0;

  function automatic logic [23:0] ramWord(input logic [8:0] a);
    return 24'(a) * 24'h010101;
  endfunction

  // RAM models: one-clock read latency, data only refreshes while reads are enabled.
  assign fbA.fb_rvalid = rvalid;
  assign fbB.fb_rvalid = rvalid;
  always @(posedge clk) begin
    if (rvalid) begin
      fbA.fb_rdata <= ramWord(fbA.fb_addr);
      fbB.fb_rdata <= ramWord(fbB.fb_addr);
    end
  end

  fb_scanout #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
               .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
               .FB_W(4), .FB_H(2), .SCALE_LOG2(1), .DP(512)) dutA (
    .clk(clk), .rst(rst), .fb(fbA),
`ifdef FB_SCANOUT_PATTERN_EN
    .pat_en_i(patEn),
`endif
    .hsync_o(hsA), .vsync_o(vsA), .de_o(deA), .rgb_o(rgbA), .frame_start_o(fsA));

  fb_scanout #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
               .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
               .FB_W(2), .FB_H(1), .SCALE_LOG2(1), .DP(512)) dutB (
    .clk(clk), .rst(rst), .fb(fbB),
`ifdef FB_SCANOUT_PATTERN_EN
    .pat_en_i(patEn),
`endif
    .hsync_o(hsB), .vsync_o(vsB), .de_o(deB), .rgb_o(rgbB), .frame_start_o(fsB));

  function automatic logic [23:0] pixel(input logic de, input logic inFb, input logic [8:0] addr,
                                        input logic rv, input logic pe, input logic [2:0] bar,
                                        input logic [23:0] prev);
    if (!de)   return 24'h0;
    if (pe)    return barTab[bar];
    if (!inFb) return 24'h0;
    if (rv)    return ramWord(addr);
    return prev;
  endfunction

  // Advance one clock: rvNext/rstNext are the values driven during the cycle that begins.
  task automatic tick(input logic rvNext, input logic rstNext);
    logic        rstPrev;
    entry_t      e;
    entry_t      o;
    logic [23:0] eA, eB;
    rstPrev = rst;
    @(posedge clk);
    #1;
    rst    = rstNext;
    rvalid = rvNext;
    if (rstPrev) begin
      hm = 0;
      vm = 0;
      q.delete();
    end else if (hm == HT - 1) begin
      hm = 0;
      vm = (vm == VT - 1) ? 0 : vm + 1;
    end else begin
      hm++;
    end
    e.h     = hm;
    e.v     = vm;
    e.hs    = !(hm >= HA + HF && hm < HA + HF + HS);
    e.vs    = !(vm >= VA + VF && vm < VA + VF + VS);
    e.de    = hm < HA && vm < VA;
    e.fs    = hm == 0 && vm == 0;
    e.inA   = (hm / 2) < 4 && (vm / 2) < 2;
    e.inB   = (hm / 2) < 2 && (vm / 2) < 1;
    e.addrA = 9'((vm / 2) * 4 + hm / 2);
    e.addrB = 9'(hm / 2);
    e.bar   = 3'((hm * 8) / HA);
    e.rv    = rvNext;
    e.pe    = patEn;
    q.push_back(e);
    eA    = 24'h0;
    eB    = 24'h0;
    expOk = 1'b0;
    if (q.size() == 4) begin
      o      = q[0];
      eA     = pixel(o.de, o.inA, o.addrA, q[1].rv, q[2].pe, o.bar, prevA);
      eB     = pixel(o.de, o.inB, o.addrB, q[1].rv, q[2].pe, o.bar, prevB);
      expVec = {o.hs, o.vs, o.de, o.fs, o.hs, o.vs, o.de, o.fs, eA, eB};
      expH   = o.h;
      expV   = o.v;
      expOk  = 1'b1;
      void'(q.pop_front());
    end
    prevA = eA;
    prevB = eB;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    total++;
    if ({hsA, vsA, deA, fsA, rgbA, fbA.fb_addr} !== {4'b1100, 24'h0, 9'h0}) begin
      bad++;
      $display("[TB] FAIL reset_state got=%h want=%h", {hsA, vsA, deA, fsA, rgbA, fbA.fb_addr},
               {4'b1100, 24'h0, 9'h0});
    end
    tick(1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick(1'b1, 1'b0);
      total++;
      if ({deA, fsA} !== ((i == 3) ? 2'b11 : 2'b00)) begin
        bad++;
        $display("[TB] FAIL first_de clk=%0d got=%b want=%b", i, {deA, fsA}, (i == 3) ? 2'b11 : 2'b00);
      end
    end
  endtask

  task automatic test_raster();
    for (int i = 0; i < 2 * HT * VT; i++) begin
      tick(1'b1, 1'b0);
      if (expOk) begin
        total++;
        if ({hsA, vsA, deA, fsA, hsB, vsB, deB, fsB, rgbA, rgbB} !== expVec) begin
          bad++;
          $display("[TB] FAIL raster h=%0d v=%0d got=%h want=%h", expH, expV,
                   {hsA, vsA, deA, fsA, hsB, vsB, deB, fsB, rgbA, rgbB}, expVec);
        end
        if (expV == 2 && expH == 0) begin
          total++;
          if (rgbA !== 24'h040404) begin
            bad++;
            $display("[TB] FAIL line2_start got=%h want=%h", rgbA, 24'h040404);
          end
        end
      end
    end
  endtask

  task automatic test_sync_timing();
    int hLow = 0, vLow = 0, firstFall = -1, secondFall = -1;
    logic prevHs = 1'b1;
    for (int i = 0; i < HT * VT; i++) begin
      tick(1'b1, 1'b0);
      if (!hsA) hLow++;
      if (!vsA) vLow++;
      if (prevHs && !hsA) begin
        if (firstFall < 0)       firstFall = i;
        else if (secondFall < 0) secondFall = i;
      end
      prevHs = hsA;
    end
    total++;
    if (secondFall - firstFall !== HT) begin
      bad++;
      $display("[TB] FAIL hsync_period got=%0d want=%0d", secondFall - firstFall, HT);
    end
    total++;
    if (hLow !== HS * VT) begin
      bad++;
      $display("[TB] FAIL hsync_low got=%0d want=%0d", hLow, HS * VT);
    end
    total++;
    if (vLow !== VS * HT) begin
      bad++;
      $display("[TB] FAIL vsync_low got=%0d want=%0d", vLow, VS * HT);
    end
  endtask

  task automatic test_rvalid_drop();
    int waited = 0;
    while (!(hm == 4 && vm == 0) && waited < 4 * HT * VT) begin
      tick(1'b1, 1'b0);
      waited++;
    end
    total++;
    if (!(hm == 4 && vm == 0)) begin
      bad++;
      $display("[TB] FAIL drop_wait got=%0d,%0d want=4,0", hm, vm);
    end
    tick(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b0);
      if (expOk) begin
        total++;
        if ({hsA, vsA, deA, fsA, hsB, vsB, deB, fsB, rgbA, rgbB} !== expVec) begin
          bad++;
          $display("[TB] FAIL drop h=%0d v=%0d got=%h want=%h", expH, expV,
                   {hsA, vsA, deA, fsA, hsB, vsB, deB, fsB, rgbA, rgbB}, expVec);
        end
        if (expV == 0 && (expH == 4 || expH == 5)) begin
          total++;
          if (rgbA !== ((expH == 4) ? 24'h010101 : 24'h020202)) begin
            bad++;
            $display("[TB] FAIL drop_hold h=%0d got=%h want=%h", expH, rgbA,
                     (expH == 4) ? 24'h010101 : 24'h020202);
          end
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int waited = 0;
    while (!(hm == 4 && vm == 2) && waited < 4 * HT * VT) begin
      tick(1'b1, 1'b0);
      waited++;
    end
    tick(1'b1, 1'b1);
    total++;
    if (!(hm == 5 && vm == 2)) begin
      bad++;
      $display("[TB] FAIL midreset_wait got=%0d,%0d want=5,2", hm, vm);
    end
    tick(1'b1, 1'b0);
    total++;
    if ({hsA, vsA, deA, fsA, rgbA} !== {4'b1100, 24'h0}) begin
      bad++;
      $display("[TB] FAIL midreset_out got=%h want=%h", {hsA, vsA, deA, fsA, rgbA}, {4'b1100, 24'h0});
    end
    for (int i = 1; i <= 3; i++) begin
      tick(1'b1, 1'b0);
      total++;
      if (fsA !== (i == 3)) begin
        bad++;
        $display("[TB] FAIL midreset_fs clk=%0d got=%b want=%b", i, fsA, i == 3);
      end
    end
  endtask

  task automatic test_back_to_back();
    int firstFs = -1, secondFs = -1;
    for (int i = 0; i < 3 * HT * VT && secondFs < 0; i++) begin
      tick(1'b1, 1'b0);
      if (fsA === 1'b1) begin
        if (firstFs < 0) firstFs = i;
        else             secondFs = i;
      end
      if (expOk && deA === 1'b1 && expH >= 4) begin
        total++;
        if (rgbB !== 24'h0) begin
          bad++;
          $display("[TB] FAIL outside_fb h=%0d v=%0d got=%h want=%h", expH, expV, rgbB, 24'h0);
        end
      end
    end
    total++;
    if (secondFs - firstFs !== HT * VT || secondFs < 0) begin
      bad++;
      $display("[TB] FAIL frame_period got=%0d want=%0d", secondFs - firstFs, HT * VT);
    end
  endtask

`ifdef FB_SCANOUT_PATTERN_EN
  task automatic test_pattern();
    patEn = 1'b1;
    for (int i = 0; i < HT * VT + 3; i++) begin
      tick(1'b1, 1'b0);
      if (expOk) begin
        total++;
        if ({hsA, vsA, deA, fsA, hsB, vsB, deB, fsB, rgbA, rgbB} !== expVec) begin
          bad++;
          $display("[TB] FAIL pattern h=%0d v=%0d got=%h want=%h", expH, expV,
                   {hsA, vsA, deA, fsA, hsB, vsB, deB, fsB, rgbA, rgbB}, expVec);
        end
        if (expV == 1 && (expH == 0 || expH == 1 || expH == 7)) begin
          total++;
          if (rgbA !== ((expH == 0) ? 24'hFFFFFF : (expH == 1) ? 24'hFFFF00 : 24'h000000)) begin
            bad++;
            $display("[TB] FAIL pattern_bar h=%0d got=%h", expH, rgbA);
          end
        end
      end
    end
    patEn = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_raster();
    test_sync_timing();
    test_rvalid_drop();
    test_mid_reset();
    test_back_to_back();
`ifdef FB_SCANOUT_PATTERN_EN
    test_pattern();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
